// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blit engine: sprite ids, the sprite geometry
// table that describes where each image lives in the shared ROM, and FSM states.
package sprite_pkg;

    typedef enum logic [2:0] {
        VERM   = 3'd0,
        MOLE   = 3'd1,
        ESCAPE = 3'd2,
        DIRT   = 3'd3,
        TEST   = 3'd4
    } sprite_id_e;

    localparam int SPRITE_COUNT = 5;

    // DIRT is a reserved zero-size slot; TEST sits below VERM at the bottom of the ROM.
    localparam logic [15:0] SPRITE_BASE [SPRITE_COUNT] = '{16'd8, 16'd264, 16'd520, 16'd776, 16'd0};
    localparam logic [7:0]  SPRITE_W    [SPRITE_COUNT] = '{8'd16, 8'd16, 8'd32, 8'd0, 8'd4};
    localparam logic [7:0]  SPRITE_H    [SPRITE_COUNT] = '{8'd16, 8'd16, 8'd8, 8'd0, 8'd2};

    localparam int PIX_TRANSPARENT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } blit_state_e;

    typedef struct packed {
        logic [15:0] base;
        logic [7:0]  w;
        logic [7:0]  h;
    } sprite_geom_t;

    function automatic sprite_geom_t geom_lookup(input int idx, input int num_valid);
        sprite_geom_t g;
        logic [2:0]   sel;
        sel = idx[2:0];
        if ((idx >= 32'sd0) && (idx < num_valid) && (idx < SPRITE_COUNT)) begin
            g.base = SPRITE_BASE[sel];
            g.w    = SPRITE_W[sel];
            g.h    = SPRITE_H[sel];
        end else begin
            g = '0;
        end
        return g;
    endfunction

endpackage

// File: rtl/sprite_geom_lut.sv
// Sprite geometry lookup: captures base/width/height when a draw is accepted and
// flags zero-size (or out-of-range) sprites combinationally for the accept decision.
module sprite_geom_lut
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 5,
    parameter int ADDR_W      = 15,
    parameter int DIM_W       = 8,
    parameter int ID_W        = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ID_W-1:0]   id,
    input  logic              load,
    output logic [ADDR_W-1:0] base_r,
    output logic [DIM_W-1:0]  w_r,
    output logic [DIM_W-1:0]  h_r,
    output logic              zero_size_s
);

    sprite_geom_t geom_s;

    // Table read for the id currently on the request bus
    always_comb begin
        geom_s      = geom_lookup(int'(id), NUM_SPRITES);
        zero_size_s = (geom_s.w == 8'd0) || (geom_s.h == 8'd0);
    end

    // Geometry held for the whole draw
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            base_r <= '0;
            w_r    <= '0;
            h_r    <= '0;
        end else if (load) begin
            base_r <= ADDR_W'(geom_s.base);
            w_r    <= DIM_W'(geom_s.w);
            h_r    <= DIM_W'(geom_s.h);
        end else begin
            base_r <= base_r;
            w_r    <= w_r;
            h_r    <= h_r;
        end
    end

endmodule

// File: rtl/sprite_blit_engine.sv
// Sprite fetch engine: walks one sprite's region of the shared ROM in raster order
// (optionally mirrored) and streams backpressured pixels to the frame-buffer writer.
module sprite_blit_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES      = 5,
    parameter int ADDR_W           = 15,
    parameter int PIX_W            = 1,
    parameter int COORD_W          = 10,
    parameter int DIM_W            = 8,
    parameter int SKIP_TRANSPARENT = 1,
    localparam int ID_W            = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ID_W-1:0]    req_id,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic               req_mirror,
    input  logic               abort,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIX_W-1:0]   rom_q,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [PIX_W-1:0]   pix_data,
    output logic               busy,
    output logic               done
);

    blit_state_e        state_r, state_nxt_s;
    logic [ADDR_W-1:0]  base_r, row_off_r, s1_addr_r, row_base_s, fetch_addr_s;
    logic [DIM_W-1:0]   w_r, h_r, col_r, row_r, col_term_s;
    logic [COORD_W-1:0] x0_r, y0_r, s1_x_r, s1_y_r;
    logic               mirror_r, s1_valid_r, zero_size_s, accept_s;
    logic               transparent_s, consumed_s, adv_s, last_col_s, last_s;

    sprite_geom_lut #(
        .NUM_SPRITES(NUM_SPRITES),
        .ADDR_W     (ADDR_W),
        .DIM_W      (DIM_W),
        .ID_W       (ID_W)
    ) u_geom (
        .clock      (clock),
        .resetn     (resetn),
        .id         (req_id),
        .load       (accept_s),
        .base_r     (base_r),
        .w_r        (w_r),
        .h_r        (h_r),
        .zero_size_s(zero_size_s)
    );

    // Handshake terms and fetch address; row_base is kept as an offset so no multiplier is needed
    always_comb begin
        accept_s      = (state_r == ST_IDLE) && req_valid;
        transparent_s = (SKIP_TRANSPARENT != 32'sd0) && (rom_q == PIX_W'(PIX_TRANSPARENT));
        consumed_s    = pix_ready || transparent_s;
        adv_s         = !s1_valid_r || consumed_s;
        last_col_s    = (col_r == (w_r - DIM_W'(1)));
        last_s        = last_col_s && (row_r == (h_r - DIM_W'(1)));
        col_term_s    = mirror_r ? (w_r - DIM_W'(1) - col_r) : col_r;
        row_base_s    = base_r + row_off_r;
        fetch_addr_s  = row_base_s + ADDR_W'(col_term_s);
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks any advance
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = zero_size_s ? ST_FINISH : ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_nxt_s = ST_FINISH;
                end else if (adv_s && last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (abort || consumed_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs; while stalled the ROM is re-presented the stage-1 address so rom_q stays put
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            ST_IDLE:  req_ready = 1'b1;
            ST_FETCH: busy      = 1'b1;
            ST_DRAIN: busy      = 1'b1;
            ST_FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
        rom_addr  = ((state_r == ST_FETCH) && adv_s) ? fetch_addr_s : s1_addr_r;
        pix_valid = s1_valid_r && !transparent_s;
        pix_x     = s1_x_r;
        pix_y     = s1_y_r;
        pix_data  = rom_q;
    end

    // Raster counters and stage-1 register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x0_r       <= '0;
            y0_r       <= '0;
            mirror_r   <= 1'b0;
            col_r      <= '0;
            row_r      <= '0;
            row_off_r  <= '0;
            s1_valid_r <= 1'b0;
            s1_x_r     <= '0;
            s1_y_r     <= '0;
            s1_addr_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        x0_r      <= req_x;
                        y0_r      <= req_y;
                        mirror_r  <= req_mirror;
                        col_r     <= '0;
                        row_r     <= '0;
                        row_off_r <= '0;
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        s1_valid_r <= 1'b0;
                    end else if (adv_s) begin
                        s1_valid_r <= 1'b1;
                        s1_x_r     <= x0_r + COORD_W'(col_r);
                        s1_y_r     <= y0_r + COORD_W'(row_r);
                        s1_addr_r  <= fetch_addr_s;
                        if (last_col_s) begin
                            col_r     <= '0;
                            row_r     <= row_r + DIM_W'(1);
                            row_off_r <= row_off_r + ADDR_W'(w_r);
                        end else begin
                            col_r <= col_r + DIM_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort || consumed_s) begin
                        s1_valid_r <= 1'b0;
                    end
                end
                ST_FINISH: s1_valid_r <= 1'b0;
                default:   s1_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed bench for sprite_blit_engine: one instance without and one with
// transparent-pixel skipping, each with its own synchronous ROM model.
module tb_sprite_blit_engine;
    import sprite_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_mirror = 1'b0, abort = 1'b0, pix_ready = 1'b1;
    logic [2:0]  req_id = 3'd0;
    logic [9:0]  req_x = 10'd0, req_y = 10'd0;

    logic        req_ready0, pix_valid0, busy0, done0, rom_q0, pix_data0;
    logic        req_ready1, pix_valid1, busy1, done1, rom_q1, pix_data1;
    logic [14:0] rom_addr0, rom_addr1;
    logic [14:0] rom_reg0 = 15'd0, rom_reg1 = 15'd0;
    logic [9:0]  pix_x0, pix_y0, pix_x1, pix_y1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id; int x; int y; int mir;
        int base; int w; int h;
        int stall_at; int lat;
    } vec_t;
    vec_t vecs [8];

    always #5 clock = ~clock;

    // ROM models: registered address, combinational data
    always @(posedge clock) begin
        rom_reg0 <= rom_addr0;
        rom_reg1 <= rom_addr1;
    end
    assign rom_q0 = rom_reg0[0];
    assign rom_q1 = (rom_reg1[1:0] == 2'd0) || (rom_reg1[1:0] == 2'd3);

    sprite_blit_engine #(.SKIP_TRANSPARENT(0)) u_dut (
        .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready0),
        .req_id(req_id), .req_x(req_x), .req_y(req_y), .req_mirror(req_mirror),
        .abort(abort), .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_valid(pix_valid0),
        .pix_ready(pix_ready), .pix_x(pix_x0), .pix_y(pix_y0), .pix_data(pix_data0),
        .busy(busy0), .done(done0)
    );

    sprite_blit_engine #(.SKIP_TRANSPARENT(1)) u_dut_skip (
        .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready1),
        .req_id(req_id), .req_x(req_x), .req_y(req_y), .req_mirror(req_mirror),
        .abort(abort), .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_valid(pix_valid1),
        .pix_ready(pix_ready), .pix_x(pix_x1), .pix_y(pix_y1), .pix_data(pix_data1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_addr(input int base, input int w, input int k, input int mir);
        int row, col;
        row = k / w;
        col = k % w;
        return (base + row * w + ((mir != 0) ? (w - 1 - col) : col)) % 32768;
    endfunction

    function automatic int skip_val(input int a);
        return (((a % 4) == 0) || ((a % 4) == 3)) ? 1 : 0;
    endfunction

    task automatic run_draw(input vec_t v);
        int k, ks, n, lat0, lat1, stall_cnt, a;
        k = 0; ks = 0; lat0 = -1; lat1 = -1; stall_cnt = 0;
        n = v.w * v.h;
        @(negedge clock);
        check("idle_ready", int'(req_ready0), 1);
        req_valid  = 1'b1;
        req_id     = 3'(v.id);
        req_x      = 10'(v.x);
        req_y      = 10'(v.y);
        req_mirror = v.mir[0];
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int cyc = 1; (cyc <= v.lat + 20) && ((lat0 < 0) || (lat1 < 0)); cyc++) begin
            @(negedge clock);
            pix_ready = 1'b1;
            if (pix_valid0 && (k == v.stall_at) && (stall_cnt < 3)) begin
                pix_ready = 1'b0;
                stall_cnt++;
            end
            #1;
            if (cyc == 1) begin
                check("busy_after_accept", int'(busy0), 1);
                check("ready_after_accept", int'(req_ready0), 0);
            end
            if (!pix_ready && pix_valid0 && (k < n)) begin
                a = exp_addr(v.base, v.w, k, v.mir);
                check("stall_rom_addr", int'(rom_addr0), a);
                check("stall_pix_x", int'(pix_x0), (v.x + k % v.w) % 1024);
                check("stall_pix_data", int'(pix_data0), a % 2);
            end
            if (lat0 < 0) begin
                if (pix_valid0 && pix_ready) begin
                    if (k < n) begin
                        a = exp_addr(v.base, v.w, k, v.mir);
                        check("pix_x", int'(pix_x0), (v.x + k % v.w) % 1024);
                        check("pix_y", int'(pix_y0), (v.y + k / v.w) % 1024);
                        check("pix_data", int'(pix_data0), a % 2);
                        check("rom_addr_seq", int'(rom_reg0), a);
                    end else begin
                        check("extra_pixel", k, n - 1);
                    end
                    k++;
                end
                if (done0) begin
                    lat0 = cyc;
                    check("done_latency", cyc, v.lat);
                    check("pixel_count", k, n);
                    check("no_pix_at_done", int'(pix_valid0), 0);
                end
            end
            if (lat1 < 0) begin
                if (pix_valid1 && pix_ready) begin
                    while ((ks < n) && (skip_val(exp_addr(v.base, v.w, ks, v.mir)) == 0)) ks++;
                    if (ks < n) begin
                        check("skip_pix_x", int'(pix_x1), (v.x + ks % v.w) % 1024);
                        check("skip_pix_y", int'(pix_y1), (v.y + ks / v.w) % 1024);
                        check("skip_pix_data", int'(pix_data1), 1);
                    end else begin
                        check("skip_extra_pixel", ks, n - 1);
                    end
                    ks++;
                end
                if (done1) begin
                    lat1 = cyc;
                    while ((ks < n) && (skip_val(exp_addr(v.base, v.w, ks, v.mir)) == 0)) ks++;
                    check("skip_pixel_count", ks, n);
                    if (v.stall_at < 0) check("skip_done_latency", cyc, v.lat);
                end
            end
        end
        if (lat0 < 0) check("done_timeout", 0, 1);
        if (lat1 < 0) check("skip_done_timeout", 0, 1);
        pix_ready = 1'b1;
    endtask

    initial begin
        int k;
        int got;
        vecs[0] = '{int'(TEST),   10,   20,   0, 0,   4,  2,  -1, 10};
        vecs[1] = '{int'(TEST),   10,   20,   1, 0,   4,  2,  -1, 10};
        vecs[2] = '{int'(TEST),   10,   20,   0, 0,   4,  2,   2, 13};
        vecs[3] = '{int'(DIRT),   10,   20,   0, 776, 0,  0,  -1, 1};
        vecs[4] = '{7,            10,   20,   0, 0,   0,  0,  -1, 1};
        vecs[5] = '{int'(TEST),   1022, 1023, 0, 0,   4,  2,  -1, 10};
        vecs[6] = '{int'(ESCAPE), 100,  50,   1, 520, 32, 8,  -1, 258};
        vecs[7] = '{int'(VERM),   0,    0,    0, 8,   16, 16, -1, 258};

        #2;
        check("rst_req_ready", int'(req_ready0), 1);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_pix_valid", int'(pix_valid0), 0);
        check("rst_rom_addr", int'(rom_addr0), 0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) run_draw(vecs[i]);

        // Abort while the third pixel is on the bus
        @(negedge clock);
        req_valid = 1'b1; req_id = 3'(TEST); req_x = 10'd10; req_y = 10'd20; req_mirror = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        k = 0; got = 0;
        for (int c = 0; (c < 20) && (got == 0); c++) begin
            @(negedge clock);
            #1;
            if (pix_valid0) begin
                if (k == 2) begin
                    abort = 1'b1;
                    got = 1;
                end
                k++;
            end
        end
        check("abort_reached_pixel3", got, 1);
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock); #1;
        check("abort_done", int'(done0), 1);
        check("abort_no_pix", int'(pix_valid0), 0);
        @(negedge clock); #1;
        check("abort_ready", int'(req_ready0), 1);
        check("abort_no_pix_after", int'(pix_valid0), 0);
        check("abort_single_done", int'(done0), 0);

        // Reset pulsed mid-draw
        @(negedge clock);
        req_valid = 1'b1; req_id = 3'(TEST); req_x = 10'd10; req_y = 10'd20; req_mirror = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_req_ready", int'(req_ready0), 1);
        check("midrst_busy", int'(busy0), 0);
        check("midrst_done", int'(done0), 0);
        check("midrst_pix_valid", int'(pix_valid0), 0);
        check("midrst_rom_addr", int'(rom_addr0), 0);
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock); #1;
            check("midrst_no_done", int'(done0), 0);
        end
        run_draw(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
